// File: rtl/balance_bcd_converter.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one input bit per clock. The input is latched when start is accepted, and
// bcd/digit_cnt only change on the single DONE cycle. Downstream logic
// therefore always sees a complete, stable result.
module balance_bcd_converter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      balance,
    input  logic                  start,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            digit_cnt
);

    // DIGITS decimal digits hold about DIGITS*3.33 bits of binary range.
    if (DIGITS * 333 < WIDTH * 100) begin : g_digits_check
        $error("balance_bcd_converter: DIGITS too small for WIDTH");
    end

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [4*DIGITS-1:0]   scratch_q, scratch_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [3:0]            digit_cnt_q, digit_cnt_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;

    logic [4*DIGITS-1:0]   scratch_adj;
    logic [3:0]            top_cnt;

    // Add-3 correction: any digit of 5 or more would become 10 or more after
    // the shift, so it is pre-biased and the carry lands in the next digit.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Significant-digit count: position of the highest nonzero digit plus one.
    // A value of zero still reports one digit.
    always_comb begin
        top_cnt = 4'd1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] != 4'd0) begin
                top_cnt = 4'(i + 1);
            end
        end
    end

    // Next-state logic for the IDLE -> CONV -> DONE -> IDLE sequence.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        digit_cnt_d = digit_cnt_q;
        valid_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = balance;
                    scratch_d = '0;
                    cnt_d     = CntW'(WIDTH);
                    state_d   = StConv;
                end
            end
            StConv: begin
                // Adjust and shift happen together: {scratch, shift} << 1
                scratch_d = {scratch_adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d       = scratch_q;
                digit_cnt_d = top_cnt;
                valid_d     = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StIdle);
    end

    // State and registered outputs; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            digit_cnt_q <= 4'd1;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            digit_cnt_q <= digit_cnt_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
        end
    end

    assign ready     = ready_q;
    assign valid     = valid_q;
    assign bcd       = bcd_q;
    assign digit_cnt = digit_cnt_q;

endmodule
